// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU, LD, FPU) driving a registered register-file write port.
// Optional pending-write scoreboard is built when REGFILE_WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_addr,
  input  logic [31:0] fpu_data,
  output logic        alu_ready,
  output logic        ld_ready,
  output logic        fpu_ready,
  input  logic        issue_valid,
  input  logic        issue_float,
  input  logic [4:0]  issue_addr,
  input  logic        chk_float,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        busy1,
  output logic        busy2,
  output logic        RegWrite,
  output logic        FloatRegWrite,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic [31:0] write_data_float
);

  typedef enum logic [1:0] {
    RR_ALU = 2'd0,
    RR_LD  = 2'd1,
    RR_FPU = 2'd2
  } rr_t;

  rr_t        rr_ptr;
  logic [2:0] grant;

  // Grant already includes valid, so a set grant bit is a completed handshake.
  always_comb begin
    grant = '0;
    case (rr_ptr)
      RR_LD: begin
        if (ld_valid)       grant = 3'b010;
        else if (fpu_valid) grant = 3'b100;
        else if (alu_valid) grant = 3'b001;
      end
      RR_FPU: begin
        if (fpu_valid)      grant = 3'b100;
        else if (alu_valid) grant = 3'b001;
        else if (ld_valid)  grant = 3'b010;
      end
      default: begin
        if (alu_valid)      grant = 3'b001;
        else if (ld_valid)  grant = 3'b010;
        else if (fpu_valid) grant = 3'b100;
      end
    endcase
    if (reset) grant = '0;
  end

  assign alu_ready = grant[0];
  assign ld_ready  = grant[1];
  assign fpu_ready = grant[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr           <= RR_ALU;
      RegWrite         <= 1'b0;
      FloatRegWrite    <= 1'b0;
      write_addr       <= '0;
      write_data       <= '0;
      write_data_float <= '0;
    end else begin
      RegWrite      <= 1'b0;
      FloatRegWrite <= 1'b0;
      if (grant[0]) begin
        rr_ptr           <= RR_LD;
        RegWrite         <= (alu_addr != 5'd0);
        write_addr       <= alu_addr;
        write_data       <= alu_data;
        write_data_float <= '0;
      end else if (grant[1]) begin
        rr_ptr           <= RR_FPU;
        RegWrite         <= (ld_addr != 5'd0);
        write_addr       <= ld_addr;
        write_data       <= ld_data;
        write_data_float <= '0;
      end else if (grant[2]) begin
        rr_ptr           <= RR_ALU;
        FloatRegWrite    <= 1'b1;
        write_addr       <= fpu_addr;
        write_data       <= '0;
        write_data_float <= fpu_data;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [31:0] pend_int;
  logic [31:0] pend_flt;

  // Clears are issued before sets so a same-edge issue to the same bit wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_int <= '0;
      pend_flt <= '0;
    end else begin
      if (RegWrite)      pend_int[write_addr] <= 1'b0;
      if (FloatRegWrite) pend_flt[write_addr] <= 1'b0;
      if (issue_valid) begin
        if (issue_float)               pend_flt[issue_addr] <= 1'b1;
        else if (issue_addr != 5'd0)   pend_int[issue_addr] <= 1'b1;
      end
    end
  end

  assign busy1 = chk_float ? pend_flt[chk_addr1] : pend_int[chk_addr1];
  assign busy2 = chk_float ? pend_flt[chk_addr2] : pend_int[chk_addr2];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_valid, issue_float, issue_addr,
                              chk_float, chk_addr1, chk_addr2};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; busy expectations follow
// whether REGFILE_WB_SCOREBOARD_EN is defined for the build.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, fpu_valid;
  logic [4:0]  alu_addr, ld_addr, fpu_addr;
  logic [31:0] alu_data, ld_data, fpu_data;
  logic        alu_ready, ld_ready, fpu_ready;
  logic        issue_valid, issue_float;
  logic [4:0]  issue_addr;
  logic        chk_float;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        busy1, busy2;
  logic        RegWrite, FloatRegWrite;
  logic [4:0]  write_addr;
  logic [31:0] write_data, write_data_float;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .fpu_valid(fpu_valid), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
    .alu_ready(alu_ready), .ld_ready(ld_ready), .fpu_ready(fpu_ready),
    .issue_valid(issue_valid), .issue_float(issue_float), .issue_addr(issue_addr),
    .chk_float(chk_float), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(busy1), .busy2(busy2),
    .RegWrite(RegWrite), .FloatRegWrite(FloatRegWrite),
    .write_addr(write_addr), .write_data(write_data),
    .write_data_float(write_data_float)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; ld_valid = 0; fpu_valid = 0;
    alu_addr = 0; ld_addr = 0; fpu_addr = 0;
    alu_data = 0; ld_data = 0; fpu_data = 0;
    issue_valid = 0; issue_float = 0; issue_addr = 0;
    chk_float = 0; chk_addr1 = 0; chk_addr2 = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    // Readies must stay low during reset even with a request present.
    alu_valid = 1; ld_valid = 1; fpu_valid = 1;
    step();
    step();
    check("rst_ready", {alu_ready, ld_ready, fpu_ready}, 3'b000);
    check("rst_strobes", {RegWrite, FloatRegWrite}, 2'b00);
    check("rst_waddr", write_addr, 0);
    check("rst_wdata", write_data, 0);
    check("rst_wdataf", write_data_float, 0);
    check("rst_busy", {busy1, busy2}, 2'b00);
    idle_inputs();
    @(negedge clk);
    reset = 0;
    #1;

    // Test 1: single ALU write
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
    #1;
    check("t1_ready", {alu_ready, ld_ready, fpu_ready}, 3'b100);
    step();
    alu_valid = 0;
    check("t1_regwrite", RegWrite, 1);
    check("t1_fwrite", FloatRegWrite, 0);
    check("t1_waddr", write_addr, 5);
    check("t1_wdata", write_data, 32'h1234);
    check("t1_wdataf", write_data_float, 0);
    step();
    check("t1_idle_strobe", {RegWrite, FloatRegWrite}, 2'b00);
    check("t1_hold_addr", write_addr, 5);
    check("t1_hold_data", write_data, 32'h1234);

    // Test 2: all three continuously valid from reset
    do_reset();
    alu_valid = 1; alu_addr = 1; alu_data = 32'hA;
    ld_valid  = 1; ld_addr  = 2; ld_data  = 32'hB;
    fpu_valid = 1; fpu_addr = 3; fpu_data = 32'hC;
    for (int k = 0; k < 6; k++) begin
      #1;
      case (k % 3)
        0: check("t2_grant_alu", {alu_ready, ld_ready, fpu_ready}, 3'b100);
        1: check("t2_grant_ld",  {alu_ready, ld_ready, fpu_ready}, 3'b010);
        default: check("t2_grant_fpu", {alu_ready, ld_ready, fpu_ready}, 3'b001);
      endcase
      step();
      case (k % 3)
        0: begin
          check("t2_strobe_alu", {RegWrite, FloatRegWrite}, 2'b10);
          check("t2_addr_alu", write_addr, 1);
          check("t2_data_alu", write_data, 32'hA);
        end
        1: begin
          check("t2_strobe_ld", {RegWrite, FloatRegWrite}, 2'b10);
          check("t2_addr_ld", write_addr, 2);
          check("t2_data_ld", write_data, 32'hB);
        end
        default: begin
          check("t2_strobe_fpu", {RegWrite, FloatRegWrite}, 2'b01);
          check("t2_addr_fpu", write_addr, 3);
          check("t2_dataf_fpu", write_data_float, 32'hC);
          check("t2_data_zero", write_data, 0);
        end
      endcase
    end
    idle_inputs();
    step();
    check("t2_drain", {RegWrite, FloatRegWrite}, 2'b00);

    // Test 3: integer hazard on r7 cleared by an LD write
    issue_valid = 1; issue_float = 0; issue_addr = 7;
    step();
    issue_valid = 0;
    chk_float = 0; chk_addr1 = 7; chk_addr2 = 8;
    #1;
    check("t3_busy1_set", busy1, SB);
    check("t3_busy2_other", busy2, 0);
    ld_valid = 1; ld_addr = 7; ld_data = 32'h77;
    #1;
    check("t3_ld_ready", {alu_ready, ld_ready, fpu_ready}, 3'b010);
    step();
    ld_valid = 0;
    check("t3_strobe", RegWrite, 1);
    check("t3_busy_in_strobe", busy1, SB);
    step();
    check("t3_busy1_clear", busy1, 0);

    // Test 4: re-issue of f3 on the edge its FloatRegWrite completes
    issue_valid = 1; issue_float = 1; issue_addr = 3;
    step();
    issue_valid = 0;
    chk_float = 1; chk_addr1 = 4; chk_addr2 = 3;
    #1;
    check("t4_busy2_set", busy2, SB);
    fpu_valid = 1; fpu_addr = 3; fpu_data = 32'h3F;
    step();
    fpu_valid = 0;
    check("t4_fstrobe", FloatRegWrite, 1);
    issue_valid = 1; issue_float = 1; issue_addr = 3;
    step();
    issue_valid = 0;
    #1;
    check("t4_set_wins", busy2, SB);
    check("t4_busy1_other", busy1, 0);
    check("t4_strobe_gone", FloatRegWrite, 0);

    // Test 5: integer r0 is never written or marked; float f0 is writable
    alu_valid = 1; alu_addr = 0; alu_data = 32'hDEAD;
    #1;
    check("t5_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    check("t5_r0_noregwrite", {RegWrite, FloatRegWrite}, 2'b00);
    issue_valid = 1; issue_float = 0; issue_addr = 0;
    step();
    issue_valid = 0;
    chk_float = 0; chk_addr1 = 0; chk_addr2 = 0;
    #1;
    check("t5_r0_busy", {busy1, busy2}, 2'b00);
    fpu_valid = 1; fpu_addr = 0; fpu_data = 32'hF0;
    step();
    fpu_valid = 0;
    check("t5_f0_write", {RegWrite, FloatRegWrite}, 2'b01);
    check("t5_f0_addr", write_addr, 0);
    check("t5_f0_data", write_data_float, 32'hF0);

    // Test 6: async reset in the strobe cycle after an FPU transfer
    issue_valid = 1; issue_float = 0; issue_addr = 9;
    step();
    issue_valid = 0;
    chk_float = 0; chk_addr1 = 9; chk_addr2 = 9;
    #1;
    check("t6_busy_pre", busy1, SB);
    fpu_valid = 1; fpu_addr = 4; fpu_data = 32'h44;
    step();
    fpu_valid = 0;
    alu_valid = 1; alu_addr = 6; alu_data = 32'h66;
    check("t6_fstrobe_pre", FloatRegWrite, 1);
    #2;
    reset = 1;
    #1;
    check("t6_fstrobe_rst", FloatRegWrite, 0);
    check("t6_busy_rst", {busy1, busy2}, 2'b00);
    check("t6_ready_rst", {alu_ready, ld_ready, fpu_ready}, 3'b000);
    check("t6_dataf_rst", write_data_float, 0);
    step();
    idle_inputs();
    @(negedge clk);
    reset = 0;
    step();
    check("t6_no_strobe", {RegWrite, FloatRegWrite}, 2'b00);

    // Reset returns rr_ptr to ALU from a non-ALU position
    ld_valid = 1; ld_addr = 2; ld_data = 32'h22;
    step();
    ld_valid = 0;
    do_reset();
    alu_valid = 1; ld_valid = 1; fpu_valid = 1;
    #1;
    check("t6_ptr_alu", {alu_ready, ld_ready, fpu_ready}, 3'b100);
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
